mem_port_arbiter: RTL and testbench

Shares the CPU's single-port unified memory between instruction fetch (IF) and data load/store (DM). Accepts one request at a time, drives the memory port, waits a fixed memory latency, and returns data with a one-cycle valid pulse. Resolves simultaneous requests round-robin so neither requester starves. Sits between the CPU core's fetch and memory stages and the memory macro, inside CPU.

---
 rtl/cpu_pkg.sv | 23 ++
 rtl/rr_pick2.sv | 33 +++
 rtl/mem_port_arbiter.sv | 159 +++++++++++++++
 tb/tb_mem_port_arbiter.sv | 352 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared encodings and default widths for the CPU memory-port arbiter
//
// Contents:
//   ADDR_W_DEF / DATA_W_DEF : default address and data widths
//   state_e                 : arbiter FSM state encoding (2 bits)
//   owner_e                 : requester identity, IF = 0, DM = 1
package cpu_pkg;

   localparam int ADDR_W_DEF = 32;
   localparam int DATA_W_DEF = 32;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACCESS = 2'd1,
      ST_RESP   = 2'd2
   } state_e;

   typedef enum logic {
      OWN_IF = 1'b0,
      OWN_DM = 1'b1
   } owner_e;

endpackage

// File: rtl/rr_pick2.sv
// rtl/rr_pick2.sv - combinational 2-way round-robin picker
//
// Ports:
//   req[1:0]   in  : bit 0 = IF request, bit 1 = DM request
//   last_owner in  : requester that won the previous grant
//   gnt[1:0]   out : one-hot grant, zero when nothing is requested
//   winner     out : owner encoding of the granted requester
module rr_pick2
   import cpu_pkg::*;
(
   input  logic   [1:0] req,
   input  owner_e       last_owner,
   output logic   [1:0] gnt,
   output owner_e       winner
);

   always_comb begin
      winner = last_owner;
      gnt    = 2'b00;
      if (req == 2'b11) begin
         // Contention: whoever did not win last time goes now.
         winner = (last_owner == OWN_IF) ? OWN_DM : OWN_IF;
      end else if (req[0]) begin
         winner = OWN_IF;
      end else if (req[1]) begin
         winner = OWN_DM;
      end
      if (req != 2'b00) begin
         gnt = (winner == OWN_IF) ? 2'b01 : 2'b10;
      end
   end

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - shares one single-port memory between fetch (IF) and data (DM)
//
// Ports:
//   clk, rst                          : clock, asynchronous active-low reset
//   if_req/if_addr                    : fetch request, held until if_valid
//   if_gnt/if_valid/if_rdata          : fetch accept pulse, data-valid pulse, fetched word
//   dm_req/dm_we/dm_addr/dm_wdata     : load/store request, held until dm_valid
//   dm_gnt/dm_valid/dm_rdata          : data accept pulse, completion pulse, loaded word
//   mem_en/mem_we/mem_addr/mem_wdata  : memory strobe and command, mem_en one cycle per access
//   mem_rdata                         : memory read data, valid MEM_LAT cycles after mem_en
//   busy                              : high whenever the arbiter is not idle
module mem_port_arbiter
   import cpu_pkg::*;
#(
   parameter int ADDR_W  = ADDR_W_DEF,
   parameter int DATA_W  = DATA_W_DEF,
   parameter int MEM_LAT = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   output logic              if_gnt,
   output logic              if_valid,
   output logic [DATA_W-1:0] if_rdata,
   input  logic              dm_req,
   input  logic              dm_we,
   input  logic [ADDR_W-1:0] dm_addr,
   input  logic [DATA_W-1:0] dm_wdata,
   output logic              dm_gnt,
   output logic              dm_valid,
   output logic [DATA_W-1:0] dm_rdata,
   output logic              mem_en,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              busy
);

   localparam int               CNT_W   = $clog2(MEM_LAT + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MEM_LAT);

   state_e             state_q, state_d;
   owner_e             owner_q, owner_d;
   logic   [CNT_W-1:0] cnt_q, cnt_d;

   logic               if_gnt_d, if_valid_d, dm_gnt_d, dm_valid_d, mem_en_d, mem_we_d;
   logic [DATA_W-1:0]  if_rdata_d, dm_rdata_d, mem_wdata_d;
   logic [ADDR_W-1:0]  mem_addr_d;

   logic   [1:0]       pick_gnt;
   owner_e             pick_winner;

   rr_pick2 u_pick (
      .req        ({dm_req, if_req}),
      .last_owner (owner_q),
      .gnt        (pick_gnt),
      .winner     (pick_winner)
   );

   always_comb begin
      state_d     = state_q;
      owner_d     = owner_q;
      cnt_d       = cnt_q;
      if_gnt_d    = 1'b0;
      dm_gnt_d    = 1'b0;
      if_valid_d  = 1'b0;
      dm_valid_d  = 1'b0;
      mem_en_d    = 1'b0;
      mem_we_d    = mem_we;
      mem_addr_d  = mem_addr;
      mem_wdata_d = mem_wdata;
      if_rdata_d  = if_rdata;
      dm_rdata_d  = dm_rdata;

      unique case (state_q)
         ST_IDLE: begin
            if (pick_gnt != 2'b00) begin
               // Command is latched here, so later changes on the request side are ignored.
               state_d  = ST_ACCESS;
               owner_d  = pick_winner;
               cnt_d    = '0;
               mem_en_d = 1'b1;
               if (pick_winner == OWN_IF) begin
                  if_gnt_d    = 1'b1;
                  mem_we_d    = 1'b0;
                  mem_addr_d  = if_addr;
                  mem_wdata_d = '0;
               end else begin
                  dm_gnt_d    = 1'b1;
                  mem_we_d    = dm_we;
                  mem_addr_d  = dm_addr;
                  mem_wdata_d = dm_wdata;
               end
            end
         end
         ST_ACCESS: begin
            if (cnt_q == CNT_MAX) begin
               state_d = ST_RESP;
               cnt_d   = '0;
               if (owner_q == OWN_IF) begin
                  if_rdata_d = mem_rdata;
                  if_valid_d = 1'b1;
               end else begin
                  // A store leaves dm_rdata alone; the valid pulse is only an acknowledgement.
                  if (!mem_we) begin
                     dm_rdata_d = mem_rdata;
                  end
                  dm_valid_d = 1'b1;
               end
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         ST_RESP: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= ST_IDLE;
         owner_q   <= OWN_DM;
         cnt_q     <= '0;
         if_gnt    <= 1'b0;
         if_valid  <= 1'b0;
         if_rdata  <= '0;
         dm_gnt    <= 1'b0;
         dm_valid  <= 1'b0;
         dm_rdata  <= '0;
         mem_en    <= 1'b0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         busy      <= 1'b0;
      end else begin
         state_q   <= state_d;
         owner_q   <= owner_d;
         cnt_q     <= cnt_d;
         if_gnt    <= if_gnt_d;
         if_valid  <= if_valid_d;
         if_rdata  <= if_rdata_d;
         dm_gnt    <= dm_gnt_d;
         dm_valid  <= dm_valid_d;
         dm_rdata  <= dm_rdata_d;
         mem_en    <= mem_en_d;
         mem_we    <= mem_we_d;
         mem_addr  <= mem_addr_d;
         mem_wdata <= mem_wdata_d;
         busy      <= (state_d != ST_IDLE);
      end
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - scoreboard bench for mem_port_arbiter (MEM_LAT=2 and MEM_LAT=1 builds)
module tb_mem_port_arbiter;

   localparam int AW = 32;
   localparam int DW = 32;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   logic          if_req = 1'b0, dm_req = 1'b0, dm_we = 1'b0;
   logic [AW-1:0] if_addr = '0, dm_addr = '0;
   logic [DW-1:0] dm_wdata = '0;
   logic          if_gnt, if_valid, dm_gnt, dm_valid, mem_en, mem_we, busy;
   logic [DW-1:0] if_rdata, dm_rdata, mem_wdata, mem_rdata;
   logic [AW-1:0] mem_addr;

   logic          l1_if_req = 1'b0, l1_dm_req = 1'b0, l1_dm_we = 1'b0;
   logic [AW-1:0] l1_if_addr = '0, l1_dm_addr = '0;
   logic [DW-1:0] l1_dm_wdata = '0;
   logic          l1_if_gnt, l1_if_valid, l1_dm_gnt, l1_dm_valid, l1_mem_en, l1_mem_we, l1_busy;
   logic [DW-1:0] l1_if_rdata, l1_dm_rdata, l1_mem_wdata, l1_mem_rdata;
   logic [AW-1:0] l1_mem_addr;

   int checks = 0;
   int failures = 0;
   logic [DW-1:0] q_if[$];
   logic [DW-1:0] q_dm[$];
   logic [DW-1:0] exp_dm_last = '0;

   mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(2)) dut (
      .clk(clk), .rst(rst),
      .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_valid(if_valid), .if_rdata(if_rdata),
      .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
      .dm_gnt(dm_gnt), .dm_valid(dm_valid), .dm_rdata(dm_rdata),
      .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .busy(busy)
   );

   mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(1)) dut_l1 (
      .clk(clk), .rst(rst),
      .if_req(l1_if_req), .if_addr(l1_if_addr), .if_gnt(l1_if_gnt), .if_valid(l1_if_valid),
      .if_rdata(l1_if_rdata),
      .dm_req(l1_dm_req), .dm_we(l1_dm_we), .dm_addr(l1_dm_addr), .dm_wdata(l1_dm_wdata),
      .dm_gnt(l1_dm_gnt), .dm_valid(l1_dm_valid), .dm_rdata(l1_dm_rdata),
      .mem_en(l1_mem_en), .mem_we(l1_mem_we), .mem_addr(l1_mem_addr), .mem_wdata(l1_mem_wdata),
      .mem_rdata(l1_mem_rdata), .busy(l1_busy)
   );

   function automatic logic [DW-1:0] mem_lookup(input logic [AW-1:0] a);
      case (a)
         32'h10:  return 32'hDEAD_BEEF;
         32'h08:  return 32'hCAFE_0001;
         default: return {a[15:0] ^ 16'h5A5A, a[15:0]};
      endcase
   endfunction

   // Memory models: read data is only correct in the exact cycle it is due.
   logic [1:0]    mv2 = 2'b00;
   logic [AW-1:0] ma0 = '0, ma1 = '0;
   always @(posedge clk) begin
      mv2 <= {mv2[0], mem_en};
      ma0 <= mem_addr;
      ma1 <= ma0;
   end
   assign mem_rdata = mv2[1] ? mem_lookup(ma1) : 32'hBAD0_BAD0;

   logic          mv1 = 1'b0;
   logic [AW-1:0] l1a = '0;
   always @(posedge clk) begin
      mv1 <= l1_mem_en;
      l1a <= l1_mem_addr;
   end
   assign l1_mem_rdata = mv1 ? mem_lookup(l1a) : 32'hBAD0_BAD0;

   // Scoreboard: every valid pulse pops the oldest expectation for that requester.
   logic [DW-1:0] sb_exp;
   always @(negedge clk) begin
      if (rst) begin
         if (if_valid) begin
            checks++;
            if (q_if.size() == 0) begin
               failures++;
               $display("FAIL sb_if_unexpected: if_valid with nothing pending, if_rdata=%h", if_rdata);
            end else begin
               sb_exp = q_if.pop_front();
               if (if_rdata !== sb_exp) begin
                  failures++;
                  $display("FAIL sb_if_rdata: got %h expected %h", if_rdata, sb_exp);
               end
            end
         end
         if (dm_valid) begin
            checks++;
            if (q_dm.size() == 0) begin
               failures++;
               $display("FAIL sb_dm_unexpected: dm_valid with nothing pending, dm_rdata=%h", dm_rdata);
            end else begin
               sb_exp = q_dm.pop_front();
               if (dm_rdata !== sb_exp) begin
                  failures++;
                  $display("FAIL sb_dm_rdata: got %h expected %h", dm_rdata, sb_exp);
               end
            end
         end
      end
   end

   task automatic do_reset();
      rst = 1'b0;
      if_req = 1'b0; dm_req = 1'b0; dm_we = 1'b0;
      if_addr = '0; dm_addr = '0; dm_wdata = '0;
      l1_dm_req = 1'b0; l1_dm_we = 1'b0; l1_dm_addr = '0;
      repeat (2) @(negedge clk);
      q_if.delete();
      q_dm.delete();
      exp_dm_last = '0;
      rst = 1'b1;
   endtask

   task automatic test_reset();
      rst = 1'b0;
      @(negedge clk);
      checks++;
      if ({if_gnt, if_valid, if_rdata, dm_gnt, dm_valid, dm_rdata, mem_en, mem_we, mem_addr,
           mem_wdata, busy} !== '0) begin
         failures++;
         $display("FAIL reset_outputs: mem_en=%b busy=%b mem_addr=%h if_rdata=%h dm_rdata=%h, all must be 0",
                  mem_en, busy, mem_addr, if_rdata, dm_rdata);
      end
      checks++;
      if ({l1_if_gnt, l1_if_valid, l1_dm_gnt, l1_dm_valid, l1_mem_en, l1_busy, l1_dm_rdata} !== '0) begin
         failures++;
         $display("FAIL reset_outputs_l1: mem_en=%b busy=%b dm_rdata=%h, all must be 0",
                  l1_mem_en, l1_busy, l1_dm_rdata);
      end
   endtask

   task automatic test_fetch();
      do_reset();
      if_addr = 32'h10; if_req = 1'b1;
      q_if.push_back(32'hDEAD_BEEF);
      for (int c = 1; c <= 6; c++) begin
         @(negedge clk);
         checks++;
         if (if_gnt !== (c == 1)) begin
            failures++; $display("FAIL fetch_gnt c%0d: if_gnt=%b expected %b", c, if_gnt, (c == 1));
         end
         checks++;
         if (mem_en !== (c == 1)) begin
            failures++; $display("FAIL fetch_mem_en c%0d: mem_en=%b expected %b", c, mem_en, (c == 1));
         end
         checks++;
         if (busy !== (c <= 4)) begin
            failures++; $display("FAIL fetch_busy c%0d: busy=%b expected %b", c, busy, (c <= 4));
         end
         checks++;
         if (if_valid !== (c == 4)) begin
            failures++; $display("FAIL fetch_valid c%0d: if_valid=%b expected %b", c, if_valid, (c == 4));
         end
         if (c == 1) begin
            checks++;
            if (mem_addr !== 32'h10 || mem_we !== 1'b0) begin
               failures++; $display("FAIL fetch_cmd: mem_addr=%h mem_we=%b expected 10/0", mem_addr, mem_we);
            end
         end
         if (if_valid) if_req = 1'b0;
      end
   endtask

   task automatic test_store();
      do_reset();
      dm_addr = 32'h40; dm_wdata = 32'h1234; dm_we = 1'b1; dm_req = 1'b1;
      q_dm.push_back(exp_dm_last);
      for (int c = 1; c <= 6; c++) begin
         @(negedge clk);
         checks++;
         if (dm_valid !== (c == 4)) begin
            failures++; $display("FAIL store_valid c%0d: dm_valid=%b expected %b", c, dm_valid, (c == 4));
         end
         checks++;
         if ((if_gnt | if_valid) !== 1'b0) begin
            failures++; $display("FAIL store_if_quiet c%0d: if_gnt=%b if_valid=%b expected 0", c, if_gnt, if_valid);
         end
         if (c == 1) begin
            checks++;
            if (!(mem_en === 1'b1 && mem_we === 1'b1 && mem_wdata === 32'h1234 && mem_addr === 32'h40 &&
                  dm_gnt === 1'b1)) begin
               failures++;
               $display("FAIL store_cmd: en=%b we=%b wdata=%h addr=%h gnt=%b expected 1/1/1234/40/1",
                        mem_en, mem_we, mem_wdata, mem_addr, dm_gnt);
            end
            dm_addr = 32'h44; dm_wdata = 32'hFFFF;
         end
         if (c == 2) begin
            checks++;
            if (mem_wdata !== 32'h1234 || mem_addr !== 32'h40 || mem_we !== 1'b1) begin
               failures++;
               $display("FAIL store_latched: wdata=%h addr=%h we=%b expected 1234/40/1", mem_wdata, mem_addr, mem_we);
            end
         end
         if (dm_valid) dm_req = 1'b0;
      end
   endtask

   task automatic test_contention();
      int ig[$];
      int dg[$];
      do_reset();
      if_addr = 32'h100; if_req = 1'b1;
      dm_addr = 32'h200; dm_we = 1'b0; dm_req = 1'b1;
      q_if.push_back(mem_lookup(32'h100));
      q_dm.push_back(mem_lookup(32'h200));
      for (int c = 1; c <= 20; c++) begin
         @(negedge clk);
         if (if_gnt) ig.push_back(c);
         if (dm_gnt) dg.push_back(c);
         if (if_valid) begin
            if_addr = if_addr + 32'h4;
            q_if.push_back(mem_lookup(if_addr));
         end
         if (dm_valid) begin
            dm_addr = dm_addr + 32'h4;
            q_dm.push_back(mem_lookup(dm_addr));
         end
      end
      checks++;
      if (ig.size() != 2 || ig[0] != 1 || ig[1] != 11) begin
         failures++;
         $display("FAIL contend_if_order: %0d grants, first at %0d, second at %0d; expected 2 at 1,11",
                  ig.size(), (ig.size() > 0) ? ig[0] : -1, (ig.size() > 1) ? ig[1] : -1);
      end
      checks++;
      if (dg.size() != 2 || dg[0] != 6 || dg[1] != 16) begin
         failures++;
         $display("FAIL contend_dm_order: %0d grants, first at %0d, second at %0d; expected 2 at 6,16",
                  dg.size(), (dg.size() > 0) ? dg[0] : -1, (dg.size() > 1) ? dg[1] : -1);
      end
   endtask

   task automatic test_reset_midop();
      int ncyc_valid;
      do_reset();
      if_addr = 32'h30; if_req = 1'b1;
      q_if.push_back(mem_lookup(32'h30));
      @(negedge clk);
      @(posedge clk);
      #2;
      rst = 1'b0;
      #1;
      checks++;
      if ({if_gnt, if_valid, mem_en, mem_we, mem_addr, busy} !== '0) begin
         failures++;
         $display("FAIL midop_reset_async: mem_en=%b busy=%b mem_addr=%h expected all 0", mem_en, busy, mem_addr);
      end
      if_req = 1'b0;
      q_if.delete();
      repeat (2) @(negedge clk);
      rst = 1'b1;
      ncyc_valid = 0;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         if (if_valid || busy) ncyc_valid++;
      end
      checks++;
      if (ncyc_valid != 0) begin
         failures++; $display("FAIL midop_no_valid: %0d active cycles after release, expected 0", ncyc_valid);
      end
      if_addr = 32'h20; if_req = 1'b1;
      q_if.push_back(mem_lookup(32'h20));
      for (int c = 1; c <= 5; c++) begin
         @(negedge clk);
         checks++;
         if (if_gnt !== (c == 1) || if_valid !== (c == 4)) begin
            failures++;
            $display("FAIL midop_refetch c%0d: gnt=%b valid=%b expected %b/%b", c, if_gnt, if_valid, (c == 1), (c == 4));
         end
         if (if_valid) if_req = 1'b0;
      end
   endtask

   task automatic test_back_to_back();
      int gc[$];
      int nvalid;
      do_reset();
      nvalid = 0;
      if_addr = 32'h10; if_req = 1'b1;
      q_if.push_back(32'hDEAD_BEEF);
      for (int c = 1; c <= 11; c++) begin
         @(negedge clk);
         if (if_gnt) gc.push_back(c);
         if (if_valid) begin
            if (nvalid == 0) begin
               if_addr = 32'h14;
               q_if.push_back(mem_lookup(32'h14));
            end else begin
               if_req = 1'b0;
            end
            nvalid++;
         end
      end
      checks++;
      if (gc.size() != 2 || gc[0] != 1 || gc[1] != 6) begin
         failures++;
         $display("FAIL b2b_gnt: %0d grants, first at %0d, second at %0d; expected 2 at 1,6",
                  gc.size(), (gc.size() > 0) ? gc[0] : -1, (gc.size() > 1) ? gc[1] : -1);
      end
      checks++;
      if (nvalid != 2) begin
         failures++; $display("FAIL b2b_valid_count: %0d valid pulses, expected 2", nvalid);
      end
   endtask

   task automatic test_lat1();
      do_reset();
      l1_dm_addr = 32'h8; l1_dm_we = 1'b0; l1_dm_req = 1'b1;
      for (int c = 1; c <= 5; c++) begin
         @(negedge clk);
         checks++;
         if (l1_dm_gnt !== (c == 1) || l1_dm_valid !== (c == 3) || l1_busy !== (c <= 3)) begin
            failures++;
            $display("FAIL lat1_timing c%0d: gnt=%b valid=%b busy=%b expected %b/%b/%b",
                     c, l1_dm_gnt, l1_dm_valid, l1_busy, (c == 1), (c == 3), (c <= 3));
         end
         if (c == 3) begin
            checks++;
            if (l1_dm_rdata !== 32'hCAFE_0001) begin
               failures++; $display("FAIL lat1_rdata: got %h expected cafe0001", l1_dm_rdata);
            end
         end
         if (l1_dm_valid) l1_dm_req = 1'b0;
      end
   endtask

   initial begin
      test_reset();
      test_fetch();
      test_store();
      test_contention();
      test_reset_midop();
      test_back_to_back();
      checks++;
      if (q_if.size() != 0 || q_dm.size() != 0) begin
         failures++;
         $display("FAIL sb_drain: %0d fetch and %0d data expectations never returned", q_if.size(), q_dm.size());
      end
      test_lat1();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
